bip_run_ctrl: RTL and testbench
===============================

BIP_RUN_CTRL -- requirements
Module: bip_run_ctrl

Interface
REQ-001 Parameter NB_DATA, default 16: accumulator width.
REQ-002 Parameter NB_OPCODE, default 5: opcode width.
REQ-003 Parameter NB_PC, default 11: program-counter width.
REQ-004 Parameter HALT_OPCODE, default 5'b00000: opcode that ends a run.
REQ-005 Parameter MAX_CYCLES, default 1000, legal range 1..65535: watchdog limit in enabled cycles.
REQ-006 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-007 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_start  input  1  level run request.
REQ-009 i_opcode  input  NB_OPCODE  opcode the CPU is currently executing.
REQ-010 i_pc  input  NB_PC  current CPU program counter.
REQ-011 i_acc  input  NB_DATA  current CPU accumulator.
REQ-012 i_tx_done  input  1  one-cycle pulse from the UART transmitter: byte finished.
REQ-013 o_cpu_en  output  1  CPU clock-enable.
REQ-014 o_tx_start  output  1  one-cycle request to the UART transmitter to send o_tx_data.
REQ-015 o_tx_data  output  8  byte to transmit; stable from o_tx_start until the matching i_tx_done.
REQ-016 o_busy  output  1  high in RUN, SEND and WAIT.
REQ-017 o_done  output  1  high in DONE.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, RUN, SEND, WAIT, DONE; all outputs registered or decoded from registered state only.
REQ-019 IDLE: o_cpu_en=0; i_start=1 -> RUN; cycle counter cleared to 0 and byte index cleared to 0 on that transition.
REQ-020 RUN: o_cpu_en=1; 16-bit cycle counter increments once per RUN cycle, including the terminating cycle.
REQ-021 RUN exit on halt: i_opcode==HALT_OPCODE in a RUN cycle -> SEND next edge; timeout flag latched 0.
REQ-022 RUN exit on watchdog: the MAX_CYCLES-th RUN cycle without halt -> SEND next edge; timeout flag latched 1.
REQ-023 Halt and watchdog in the same cycle: halt wins; timeout flag = 0.
REQ-024 On the RUN exit edge, i_pc, i_acc and the incremented cycle count SHALL be latched into snapshot registers; o_cpu_en is 0 from the following cycle (latency 1).
REQ-025 Report frame: 8 bytes in order: 0xA5, {7'b0, timeout}, {5'b0, pc[10:8]}, pc[7:0], acc[15:8], acc[7:0], cyc[15:8], cyc[7:0]; upper PC byte zero-extended for any NB_PC <= 16.
REQ-026 SEND lasts exactly one cycle: o_tx_start=1, o_tx_data=frame[index] -> WAIT.
REQ-027 WAIT: o_tx_start=0; i_tx_done=1 -> index+1; -> SEND if index was < 7, else DONE.
REQ-028 i_tx_done SHALL be ignored in every state other than WAIT.
REQ-029 First o_tx_start rises in the cycle immediately after the RUN exit edge (halt opcode at cycle N -> o_tx_start high at N+1).
REQ-030 DONE: o_done=1, o_cpu_en=0; stays while i_start=1; i_start=0 -> IDLE, so a held start never re-runs.
REQ-031 Changes of i_start during RUN, SEND or WAIT SHALL have no effect.
REQ-032 Snapshot registers hold their values until the next RUN exit.

Reset
REQ-033 While i_rst_n=0, regardless of clock: state=IDLE, o_cpu_en=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, counter=0, index=0, snapshots=0, timeout flag=0.
REQ-034 Reset mid-run or mid-frame SHALL abort immediately with no partial completion; after release the block waits in IDLE for i_start=1.

Verification
REQ-035 Reset, start, HALT opcode on 5th RUN cycle with pc=0x004, acc=0x1234, i_tx_done 3 cycles after each o_tx_start -> bytes A5 00 00 04 12 34 00 05, then o_done=1.
REQ-036 MAX_CYCLES=20, never halt, pc=0x7FF, acc=0xFFFF -> o_cpu_en high exactly 20 cycles; frame A5 01 07 FF FF FF 00 14.
REQ-037 i_tx_done delayed 100 cycles, plus spurious i_tx_done pulses during RUN and SEND -> exactly 8 single-cycle o_tx_start pulses; o_tx_data stable across every wait.
REQ-038 i_rst_n low while in WAIT after byte 3 -> all outputs 0 asynchronously; after release the block stays in IDLE until start, and the next run reports a fresh count.
REQ-039 i_start held through DONE -> no second run; drop i_start for 1 cycle then raise it -> new run with counter restarted at 1.
REQ-040 MAX_CYCLES=8 with HALT opcode on the 8th RUN cycle -> status byte 00, count byte 08.

Source files
------------

// File: rtl/bip_run_ctrl.sv
// Purpose: run controller for a small accumulator CPU: gates the CPU clock-enable
//          for one run, then streams an 8-byte status report out through a UART.
// Latency: halt/watchdog seen in RUN cycle N -> o_cpu_en low and o_tx_start high at N+1.
// Backpressure: each report byte is held on o_tx_data until the transmitter pulses i_tx_done.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_start           level run request (edge of DONE->IDLE needs it low)
//   i_opcode/i_pc/i_acc  live CPU state, sampled on the run exit edge
//   i_tx_done         transmitter byte-complete pulse (only honoured in WAIT)
//   o_cpu_en          CPU clock-enable (high in RUN only)
//   o_tx_start/o_tx_data  one-cycle send request and the byte to send
//   o_busy/o_done     run/report in progress, report finished
module bip_run_ctrl #(
  parameter int                   NB_DATA     = 16,
  parameter int                   NB_OPCODE   = 5,
  parameter int                   NB_PC       = 11,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = '0,
  parameter int                   MAX_CYCLES  = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic [NB_DATA-1:0]   i_acc,
  input  logic                 i_tx_done,
  output logic                 o_cpu_en,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [15:0] MAX_CYC = 16'(MAX_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [2:0]  idx_q, idx_d;
  logic        timeout_q, timeout_d;
  logic [15:0] pc_snap_q, pc_snap_d;
  logic [15:0] acc_snap_q, acc_snap_d;
  logic [15:0] cyc_snap_q, cyc_snap_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic [15:0] cyc_inc;
  logic [2:0]  idx_inc;
  logic        halt_hit;
  logic        wdog_hit;
  logic [7:0]  next_byte;

  // The count includes the cycle being evaluated, so the watchdog fires on
  // the MAX_CYCLES-th RUN cycle and the snapshot holds the true run length.
  assign cyc_inc  = cyc_q + 16'd1;
  assign idx_inc  = idx_q + 3'd1;
  assign halt_hit = (i_opcode == HALT_OPCODE);
  assign wdog_hit = (cyc_inc == MAX_CYC);

  // Byte that follows the current one. Byte 0 is a constant header, so it can be
  // loaded on the RUN exit edge before the snapshots themselves have settled.
  always_comb begin
    next_byte = 8'h00;
    unique case (idx_inc)
      3'd0: next_byte = 8'hA5;
      3'd1: next_byte = {7'b0, timeout_q};
      3'd2: next_byte = pc_snap_q[15:8];
      3'd3: next_byte = pc_snap_q[7:0];
      3'd4: next_byte = acc_snap_q[15:8];
      3'd5: next_byte = acc_snap_q[7:0];
      3'd6: next_byte = cyc_snap_q[15:8];
      3'd7: next_byte = cyc_snap_q[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    timeout_d  = timeout_q;
    pc_snap_d  = pc_snap_q;
    acc_snap_d = acc_snap_q;
    cyc_snap_d = cyc_snap_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          cyc_d   = '0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (halt_hit || wdog_hit) begin
          state_d    = S_SEND;
          timeout_d  = !halt_hit;  // halt takes priority over a coincident watchdog
          pc_snap_d  = 16'(i_pc);
          acc_snap_d = 16'(i_acc);
          cyc_snap_d = cyc_inc;
          tx_data_d  = 8'hA5;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          idx_d = idx_inc;
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_SEND;
            tx_data_d = next_byte;
          end
        end
      end
      S_DONE: begin
        if (!i_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      idx_q      <= '0;
      timeout_q  <= 1'b0;
      pc_snap_q  <= '0;
      acc_snap_q <= '0;
      cyc_snap_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      timeout_q  <= timeout_d;
      pc_snap_q  <= pc_snap_d;
      acc_snap_q <= acc_snap_d;
      cyc_snap_q <= cyc_snap_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_cpu_en   = (state_q == S_RUN);
  assign o_tx_start = (state_q == S_SEND);
  assign o_tx_data  = tx_data_q;
  assign o_busy     = (state_q == S_RUN) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Purpose: self-checking bench for bip_run_ctrl; a CPU/UART model drives opcodes and
//          tx_done pulses, expected report bytes are queued per run and popped on o_tx_start.
// Ports: none (top-level bench).
module tb_bip_run_ctrl;

  localparam int         MAXC = 20;
  localparam logic [4:0] HALT = 5'b00000;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        tx_done = 1'b0;
  logic [4:0]  opcode  = 5'h01;
  logic [10:0] pc      = '0;
  logic [15:0] acc     = '0;
  logic        cpu_en, tx_start, busy, done;
  logic [7:0]  tx_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  bip_run_ctrl #(
    .NB_DATA    (16),
    .NB_OPCODE  (5),
    .NB_PC      (11),
    .HALT_OPCODE(HALT),
    .MAX_CYCLES (MAXC)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_opcode  (opcode),
    .i_pc      (pc),
    .i_acc     (acc),
    .i_tx_done (tx_done),
    .o_cpu_en  (cpu_en),
    .o_tx_start(tx_start),
    .o_tx_data (tx_data),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_en"}, cpu_en, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One run: queue the expected frame, raise start, act as CPU and UART until
  // o_done (or abort with reset mid-WAIT after byte number abort_at).
  task automatic run_frame(input int halt_at, input logic [10:0] pc_v, input logic [15:0] acc_v,
                           input int delay, input bit spur, input int abort_at);
    int   exp_cyc;
    bit   exp_to;
    int   en_cnt = 0;
    int   starts = 0;
    int   wait_cnt = 0;
    int   guard = 0;
    bit   prev_en = 0;
    bit   prev_st = 0;
    bit   bad = 0;
    bit   aborted = 0;
    logic [7:0] held = '0;
    logic [7:0] exp_b;
    exp_to  = (halt_at == 0) || (halt_at > MAXC);
    exp_cyc = exp_to ? MAXC : halt_at;
    exp_q.push_back(8'hA5);
    exp_q.push_back({7'b0, exp_to});
    exp_q.push_back({5'b0, pc_v[10:8]});
    exp_q.push_back(pc_v[7:0]);
    exp_q.push_back(acc_v[15:8]);
    exp_q.push_back(acc_v[7:0]);
    exp_q.push_back(8'(exp_cyc >> 8));
    exp_q.push_back(8'(exp_cyc));
    @(negedge clk);
    pc    = pc_v;
    acc   = acc_v;
    start = 1'b1;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
      tx_done = 1'b0;
      opcode  = 5'h01;
      if (cpu_en) begin
        en_cnt++;
        if (en_cnt == halt_at) opcode = HALT;
        if (spur && en_cnt == 2) tx_done = 1'b1;
        if (spur) start = (en_cnt != 3);
      end
      if (tx_start) begin
        if (prev_st) bad = 1'b1;
        starts++;
        if (starts == 1) check("exit_latency", prev_en, 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check($sformatf("byte%0d", starts - 1), tx_data, exp_b);
        end else begin
          check("extra_tx_start", starts, 8);
        end
        held     = tx_data;
        wait_cnt = delay;
        if (spur) tx_done = 1'b1;
      end else if (wait_cnt > 0) begin
        if (tx_data !== held) bad = 1'b1;
        wait_cnt--;
        if (wait_cnt == 0) begin
          tx_done = 1'b1;
        end else if (abort_at != 0 && starts == abort_at && wait_cnt == 1) begin
          #2 rst_n = 1'b0;
          #1 check_all_zero("async_reset");
          start = 1'b0;
          exp_q.delete();
          aborted = 1'b1;
          break;
        end
      end
      prev_en = cpu_en;
      prev_st = tx_start;
    end
    if (!aborted) begin
      check("cycle_budget", guard < 3000, 1);
      check("tx_start_count", starts, 8);
      check("cpu_en_cycles", en_cnt, exp_cyc);
      check("tx_stable_single", bad, 0);
      check("frame_complete", exp_q.size(), 0);
      check("done_flag", done, 1);
      check("busy_in_done", busy, 0);
      check("cpu_en_in_done", cpu_en, 0);
      exp_q.delete();
    end
  endtask

  task automatic end_run();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_done", done, 0);
  endtask

  initial begin
    bit reran;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", cpu_en, 0);

    run_frame(5, 11'h004, 16'h1234, 3, 1'b0, 0);     // A5 00 00 04 12 34 00 05
    end_run();
    run_frame(0, 11'h7FF, 16'hFFFF, 3, 1'b0, 0);     // watchdog: A5 01 07 FF FF FF 00 14
    end_run();
    run_frame(7, 11'h123, 16'hBEEF, 100, 1'b1, 0);   // slow UART, stray tx_done, start toggling
    end_run();

    run_frame(6, 11'h055, 16'h00AA, 3, 1'b0, 3);     // reset lands in WAIT after byte 3
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reran = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_en || busy || done || tx_start) reran = 1'b1;
    end
    check("idle_after_reset", reran, 0);
    run_frame(6, 11'h055, 16'h00AA, 3, 1'b0, 0);     // fresh count after abort
    end_run();

    run_frame(MAXC, 11'h200, 16'h0F0F, 2, 1'b0, 0);  // halt on the watchdog cycle: halt wins

    reran = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_en || busy) reran = 1'b1;
    end
    check("held_start_no_rerun", reran, 0);
    check("held_start_done", done, 1);
    @(negedge clk);
    start = 1'b0;
    run_frame(3, 11'h001, 16'h0001, 1, 1'b0, 0);     // counter restarts at 1
    end_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
